pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 13 +
 rtl/pipeline_ctrl_hazard_wait_timer.sv | 34 +++
 rtl/pipeline_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared CPU pipeline control types and constants
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_PEND  = 2'd1,
    RD_DRAIN = 2'd2
  } redirect_state_e;

  localparam int BRANCH_MODE_SQUASH_IF_ID = 0;
  localparam int BRANCH_MODE_DELAY_SLOT   = 1;

endpackage

// File: rtl/pipeline_ctrl_hazard_wait_timer.sv
// rtl/pipeline_ctrl_hazard_wait_timer.sv - saturating mem wait counter with sticky timeout error
module hazard_wait_timer
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic mem_done,
  output logic timeout_err
);

  localparam int W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);

  logic [W-1:0] wait_cnt;

  // The error fires on the edge where the count reaches LIMIT; the count then parks there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else if (run) begin
      if (mem_done) begin
        wait_cnt <= '0;
      end else begin
        if (wait_cnt != LIMIT) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt >= LIMIT - 1'b1) timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline stall/flush and branch redirect control
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int BRANCH_MODE    = 0,
  parameter int MEM_TIMEOUT    = 255,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic                      fetch_done,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      id_use_rs,
  input  logic                      id_use_rt,
  input  logic [REG_ADDR_WIDTH-1:0] ex_dst,
  input  logic                      ex_load,
  input  logic                      ex_branch,
  input  logic [ADDR_WIDTH-1:0]     ex_target,
  input  logic                      mem_done,
  output logic                      if_stall,
  output logic                      if_flush,
  output logic                      id_stall,
  output logic                      id_flush,
  output logic                      ex_stall,
  output logic                      ex_flush,
  output logic                      mem_stall,
  output logic                      mem_flush,
  output logic                      wb_stall,
  output logic                      wb_flush,
  output logic                      redirect_valid,
  output logic [ADDR_WIDTH-1:0]     redirect_pc,
  output logic                      mem_timeout_err,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      squash_cnt
);

  redirect_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0]   target_q, target_d;
  logic                    rs_hit, rt_hit, load_use, accept;

  assign rs_hit   = id_use_rs && (id_rs == ex_dst) && (id_rs != '0);
  assign rt_hit   = id_use_rt && (id_rt == ex_dst) && (id_rt != '0);
  assign load_use = ex_load && (rs_hit || rt_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RD_IDLE;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // Stalls chain back from later stages; run=0 forces every stage to hold and flush.
  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    redirect_valid = 1'b0;
    redirect_pc    = ex_target;
    accept         = 1'b0;

    wb_stall  = !run;
    wb_flush  = !run;
    mem_stall = !run || !mem_done;
    mem_flush = !run || !mem_done;
    ex_stall  = mem_stall;
    ex_flush  = !run || load_use;
    id_stall  = ex_stall || load_use;
    if_stall  = id_stall || !fetch_done;

    if (run) begin
      case (state_q)
        RD_IDLE: begin
          if (ex_branch && !ex_stall) begin
            accept = 1'b1;
            if (!fetch_done) begin
              redirect_valid = 1'b1;
              state_d        = RD_DRAIN;
            end else if (!if_stall) begin
              redirect_valid = 1'b1;
            end else begin
              target_d = ex_target;
              state_d  = RD_PEND;
            end
          end
        end
        RD_PEND: begin
          redirect_valid = 1'b1;
          redirect_pc    = target_q;
          if (!if_stall) state_d = RD_IDLE;
        end
        RD_DRAIN: begin
          if (fetch_done) state_d = RD_IDLE;
        end
        default: state_d = RD_IDLE;
      endcase
    end

    if_flush = !run || !fetch_done || accept || (state_q == RD_DRAIN);
    id_flush = !run || (accept && (BRANCH_MODE == BRANCH_MODE_SQUASH_IF_ID));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      squash_cnt <= '0;
    end else if (run) begin
      if (id_stall) stall_cnt <= stall_cnt + 1'b1;
      if (accept) squash_cnt <= squash_cnt + 1'b1;
    end
  end

  hazard_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .mem_done   (mem_done),
    .timeout_err(mem_timeout_err)
  );

endmodule
